instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter NB, default 32: instruction word and address width.
REQ-002 Parameter TAM_I, default 256: instruction memory depth in words; also the maximum number of words loaded per program.
REQ-003 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-004 i_reset  in  1  reset, synchronous, active-high.
REQ-005 i_start  in  1  load command; single-cycle pulse.
REQ-006 i_rx_valid  in  1  qualifies i_rx_data for exactly one cycle per byte.
REQ-007 i_rx_data  in  8  program byte; the first byte of each word is the MSB (big-endian).
REQ-008 o_instruction_write  out  1  one-cycle write strobe toward the fetch-stage instruction memory.
REQ-009 o_address_memory_ins  out  NB  byte address of the word being written.
REQ-010 o_instruction  out  NB  assembled instruction word.
REQ-011 o_busy  out  1  high in RECEIVE and WRITE.
REQ-012 o_done  out  1  level; high in DONE.
REQ-013 o_error  out  1  level; high in ERROR.
REQ-014 o_word_count  out  NB  words written since the last accepted i_start.

Function
REQ-015 States: IDLE, RECEIVE, WRITE, DONE and ERROR.
REQ-016 IDLE, DONE or ERROR, i_start=1: next state RECEIVE; clear the byte index, o_address_memory_ins and o_word_count to 0; clear o_done and o_error.
REQ-017 i_start in RECEIVE or WRITE: ignored.
REQ-018 RECEIVE, i_rx_valid=1: shift i_rx_data into the word LSB (word <= {word[NB-9:0], byte}) and increment the 2-bit byte index.
REQ-019 RECEIVE, 4th byte accepted: next state WRITE; the byte index wraps to 0.
REQ-020 WRITE lasts exactly one cycle:
  - o_instruction_write=1;
  - o_instruction holds the assembled word;
  - o_address_memory_ins holds the current byte address.
REQ-021 Latency: o_instruction_write is asserted in the cycle immediately after the 4th i_rx_valid byte.
REQ-022 A byte with i_rx_valid=1 during WRITE is accepted as byte 0 of the next word; no byte is ever dropped.
REQ-023 On leaving WRITE:
  - o_address_memory_ins += 4, modulo 2^NB;
  - o_word_count += 1.
REQ-024 WRITE exit, halt word (all ones, 32'hFFFFFFFF): next state DONE; the halt word itself is written.
REQ-025 WRITE exit, non-halt word with o_word_count reaching TAM_I: next state ERROR; no further writes occur.
REQ-026 WRITE exit, otherwise: next state RECEIVE.
REQ-027 Halt priority: a halt word in slot TAM_I goes to DONE, not ERROR.
REQ-028 Bytes received in IDLE, DONE or ERROR are discarded.
REQ-029 o_instruction_write=0 in every state other than WRITE.
REQ-030 o_instruction and o_address_memory_ins hold their values outside WRITE.

Reset
REQ-031 i_reset=1 forces, on the next edge and with priority over all inputs (including i_start and i_rx_valid):
  - state IDLE;
  - all outputs 0;
  - byte index and word register 0.
REQ-032 A reset during RECEIVE or WRITE abandons the partial word without asserting o_instruction_write.

Structure
REQ-033 The shared pipeline package holds:
  - the state encoding (3-bit);
  - HALT_INSTR = 32'hFFFFFFFF;
  - BYTES_PER_WORD = 4.
REQ-034 One sub-module, byte_assembler, SHALL contain the shift register and the byte index, and SHALL produce a word_ready pulse; the FSM stays in instruction_loader.
REQ-035 instruction_loader connects directly to the fetch stage's i_instruction_write, i_address_memory_ins and i_instruction inputs.

Verification
REQ-036 Reset, then i_start, then bytes 20,08,00,05 and FF,FF,FF,FF:
  - write 0x20080005 @0;
  - write 0xFFFFFFFF @4;
  - o_done=1 and o_word_count=2.
REQ-037 Back-to-back bytes 01,02,03,04,05,06,07,08 with i_rx_valid held high (8 consecutive cycles):
  - write 0x01020304 @0 and 0x05060708 @4;
  - each strobe one cycle after its 4th byte;
  - no byte lost.
REQ-038 TAM_I=4, five non-halt words: four writes @0, 4, 8, 12; o_error=1; the fifth word is never written.
REQ-039 TAM_I=4, three non-halt words then FFFFFFFF: four writes; o_done=1; o_error=0.
REQ-040 i_reset asserted after 2 bytes of a word: next cycle all outputs 0 and no strobe; a new i_start plus 4 bytes writes @0.
REQ-041 i_start pulsed mid-RECEIVE is ignored (address continues); i_start in DONE restarts at address 0 with o_word_count=0.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader_pkg
// Description : Shared loader state encoding and instruction constants.
// Revision    : 1.0
// ============================================================================
package instruction_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECEIVE = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } loader_state_t;

    localparam logic [31:0] HALT_INSTR     = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD = 4;

endpackage
`default_nettype wire

// File: rtl/instruction_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module      : byte_assembler
// Description : Big-endian byte-to-word shift register with word_ready pulse.
// Revision    : 1.0
// ============================================================================
module byte_assembler
    import instruction_loader_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte_data,
    output logic [NB-1:0] o_word_next,
    output logic          o_word_ready
);

    // Only the low NB-8 bits survive the next shift, so only those are stored.
    logic [NB-9:0] r_word;
    logic [1:0]    r_index;

    assign o_word_next  = {r_word, i_byte_data};
    assign o_word_ready = i_byte_valid && (r_index == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_word  <= '0;
            r_index <= 2'd0;
        end else if (i_byte_valid) begin
            r_word  <= o_word_next[NB-9:0];
            r_index <= r_index + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Loads a byte-serial program into the fetch-stage instruction
//               memory, one big-endian word per write strobe.
// Revision    : 1.0
// ============================================================================
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int NB    = 32,
    parameter int TAM_I = 256
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_rx_valid,
    input  logic [7:0]    i_rx_data,
    output logic          o_instruction_write,
    output logic [NB-1:0] o_address_memory_ins,
    output logic [NB-1:0] o_instruction,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_error,
    output logic [NB-1:0] o_word_count
);

    loader_state_t r_state;
    loader_state_t w_state_next;

    logic [NB-1:0] r_address;
    logic [NB-1:0] r_word_count;
    logic [NB-1:0] r_instruction;
    logic [NB-1:0] w_word_next;
    logic [NB-1:0] w_count_inc;
    logic          w_word_ready;
    logic          w_accept;
    logic          w_start;
    logic          w_is_halt;

    // A byte arriving during WRITE already belongs to the next word.
    assign w_accept    = i_rx_valid && ((r_state == ST_RECEIVE) || (r_state == ST_WRITE));
    assign w_start     = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                     (r_state == ST_ERROR));
    assign w_count_inc = r_word_count + NB'(1);
    assign w_is_halt   = (r_instruction == NB'(HALT_INSTR));

    byte_assembler #(
        .NB (NB)
    ) u_byte_assembler (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_start),
        .i_byte_valid (w_accept),
        .i_byte_data  (i_rx_data),
        .o_word_next  (w_word_next),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    w_state_next = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (w_word_ready) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Halt wins over the capacity limit.
                if (w_is_halt) begin
                    w_state_next = ST_DONE;
                end else if (w_count_inc == NB'(TAM_I)) begin
                    w_state_next = ST_ERROR;
                end else begin
                    w_state_next = ST_RECEIVE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_address     <= '0;
            r_word_count  <= '0;
            r_instruction <= '0;
        end else begin
            if (w_start) begin
                r_address    <= '0;
                r_word_count <= '0;
            end
            if (w_word_ready) begin
                r_instruction <= w_word_next;
            end
            if (r_state == ST_WRITE) begin
                r_address    <= r_address + NB'(4);
                r_word_count <= w_count_inc;
            end
        end
    end

    assign o_instruction_write  = (r_state == ST_WRITE);
    assign o_address_memory_ins = r_address;
    assign o_instruction        = r_instruction;
    assign o_word_count         = r_word_count;
    assign o_busy               = (r_state == ST_RECEIVE) || (r_state == ST_WRITE);
    assign o_done               = (r_state == ST_DONE);
    assign o_error              = (r_state == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Scoreboard bench for instruction_loader with a queue-based
//               program model and randomized byte traffic.
// Revision    : 1.0
// ============================================================================
module tb_instruction_loader;

    localparam int NB  = 32;
    localparam int TAM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          instruction_write;
    logic [NB-1:0] address_memory_ins;
    logic [NB-1:0] instruction;
    logic          busy;
    logic          done;
    logic          error;
    logic [NB-1:0] word_count;

    instruction_loader #(
        .NB    (NB),
        .TAM_I (TAM)
    ) dut (
        .i_clk                (clk),
        .i_reset              (reset),
        .i_start              (start),
        .i_rx_valid           (rx_valid),
        .i_rx_data            (rx_data),
        .o_instruction_write  (instruction_write),
        .o_address_memory_ins (address_memory_ins),
        .o_instruction        (instruction),
        .o_busy               (busy),
        .o_done               (done),
        .o_error              (error),
        .o_word_count         (word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];

    // Program model: a loader is idle, collecting bytes, finished or overflowed.
    typedef enum {M_IDLE, M_RECV, M_DONE, M_ERR} mmode_t;
    mmode_t      m_mode;
    bit          m_pending;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_addr;
    logic [31:0] m_count;
    logic [31:0] m_last;
    logic [31:0] m_pend_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit rst, input bit st, input bit v, input logic [7:0] d);
        logic [31:0] w;
        if (rst) begin
            m_mode    = M_IDLE;
            m_pending = 1'b0;
            m_bytes.delete();
            m_addr    = '0;
            m_count   = '0;
            m_last    = '0;
            return;
        end
        if (m_pending) begin
            if (v) m_bytes.push_back(d);
            m_pending = 1'b0;
            m_count   = m_count + 1;
            m_addr    = m_addr + 4;
            if (m_pend_word == 32'hFFFF_FFFF) m_mode = M_DONE;
            else if (m_count == TAM)          m_mode = M_ERR;
            else                              m_mode = M_RECV;
        end else if (m_mode == M_RECV) begin
            if (v) m_bytes.push_back(d);
            if (m_bytes.size() == 4) begin
                w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_bytes.delete();
                m_pending   = 1'b1;
                m_pend_word = w;
                m_last      = w;
                sbq.push_back('{cyc + 1, m_addr, w});
            end
        end else if (st) begin
            m_mode  = M_RECV;
            m_addr  = '0;
            m_count = '0;
            m_bytes.delete();
        end
    endtask

    task automatic check_status();
        chk("busy",       32'(busy),  32'(m_pending || (m_mode == M_RECV)));
        chk("done",       32'(done),  32'(!m_pending && (m_mode == M_DONE)));
        chk("error",      32'(error), 32'(!m_pending && (m_mode == M_ERR)));
        chk("word_count", word_count, m_count);
        chk("address",    address_memory_ins, m_addr);
        chk("instr_hold", instruction, m_last);
    endtask

    task automatic step(input bit rst, input bit st, input bit v, input logic [7:0] d);
        @(negedge clk);
        check_status();
        reset    = rst;
        start    = st;
        rx_valid = v;
        rx_data  = d;
        model_edge(rst, st, v, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) idle($urandom_range(1, 2));
            step(0, 0, 1, t[31:24]);
            t = t << 8;
        end
    endtask

    // Monitor: pop an expectation whenever the DUT strobes a write.
    exp_t e;
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_write expected addr=%h data=%h at cycle %0d, no strobe observed",
                     sbq[0].addr, sbq[0].data, sbq[0].cyc);
            void'(sbq.pop_front());
        end
        if (instruction_write !== 1'b0) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual addr=%h data=%h required=no write",
                         address_memory_ins, instruction);
            end else begin
                e = sbq.pop_front();
                chk("write_cycle", 32'(cyc), 32'(e.cyc));
                chk("write_addr",  address_memory_ins, e.addr);
                chk("write_data",  instruction, e.data);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_edge(1, 0, 0, 8'h00);
        step(1, 1, 1, 8'hAA);
        idle(2);
        chk("rst_address", address_memory_ins, 32'h0);
        chk("rst_write",   32'(instruction_write), 32'h0);

        // Two-word program ending in halt
        step(0, 1, 0, 8'h00);
        send_word(32'h2008_0005, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        idle(3);
        chk("t36_done",  32'(done), 32'h1);
        chk("t36_count", word_count, 32'd2);
        chk("t36_instr", instruction, 32'hFFFF_FFFF);

        // Back-to-back bytes across the WRITE cycle
        step(0, 1, 0, 8'h00);
        for (int i = 1; i <= 8; i++) step(0, 0, 1, 8'(i));
        idle(2);
        chk("t37_count", word_count, 32'd2);
        chk("t37_instr", instruction, 32'h0506_0708);
        send_word(32'hFFFF_FFFF, 1'b0);
        idle(2);

        // Capacity overflow: five non-halt words
        step(0, 1, 0, 8'h00);
        for (int i = 0; i < 5; i++) send_word(32'h1000_0000 + 32'(i), 1'b0);
        idle(3);
        chk("t38_error", 32'(error), 32'h1);
        chk("t38_count", word_count, 32'd4);

        // Halt landing in the last slot
        step(0, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++) send_word(32'h3000_0000 + 32'(i), 1'b1);
        send_word(32'hFFFF_FFFF, 1'b1);
        idle(3);
        chk("t39_done",  32'(done),  32'h1);
        chk("t39_error", 32'(error), 32'h0);
        chk("t39_count", word_count, 32'd4);

        // Reset in the middle of a word
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h12);
        step(0, 0, 1, 8'h34);
        step(1, 0, 1, 8'h56);
        idle(2);
        chk("t40_busy", 32'(busy), 32'h0);
        step(0, 1, 0, 8'h00);
        send_word(32'hCAFE_0001, 1'b0);
        idle(2);
        chk("t40_count", word_count, 32'd1);

        // Start mid-receive is ignored; start in DONE restarts
        send_word(32'h4000_0001, 1'b0);
        step(0, 0, 1, 8'h40);
        step(0, 1, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 1, 1, 8'h02);
        idle(2);
        chk("t41_count", word_count, 32'd3);
        send_word(32'hFFFF_FFFF, 1'b0);
        idle(2);
        step(0, 1, 0, 8'h00);
        idle(1);
        chk("t41_restart_count", word_count, 32'd0);
        chk("t41_restart_addr",  address_memory_ins, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 1) == 1), d);
        end
        idle(4);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
